data_memory_responder: RTL and testbench

//  Backing-memory responder for the D-cache memory port. Accepts one line-read or

---
 rtl/data_memory_responder.sv | 122 ++++++++++++
 tb/tb_data_memory_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Backing-memory responder for the D-cache: one line read or word write at a time,
// fixed go/return latency, line reads returned as BURST_WORDS beats of one word each.
module data_memory_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int REQ_LATENCY  = 5,
  parameter int RESP_LATENCY = 5,
  parameter int BURST_WORDS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_rlast,
  output logic        mem_wack
);

  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int MAX_LAT    = (REQ_LATENCY > RESP_LATENCY) ? REQ_LATENCY : RESP_LATENCY;
  localparam int CNT_W      = $clog2(MAX_LAT) + 1;
  localparam int FIRST_BEAT = RESP_LATENCY - BURST_WORDS;

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic               is_read;
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [MEM_WORDS];

  logic               accept;
  logic               last_resp;
  logic               beat_vld;
  logic               beat_last;
  logic [IDX_W-1:0]   line_base;
  logic [IDX_W-1:0]   rd_idx;
  logic               addr_unused;

  assign addr_unused = ^{mem_addr[31:IDX_W+2], mem_addr[1:0]};

  assign accept    = (state == IDLE) && (mem_read_en || mem_write_en);
  assign last_resp = (state == RESP) && (cnt == CNT_W'(RESP_LATENCY - 1));
  assign mem_ready = (state == IDLE);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          nxt_state = DELAY;
          nxt_cnt   = '0;
        end
      end
      DELAY: begin
        if (cnt == CNT_W'(REQ_LATENCY - 1)) begin
          nxt_state = RESP;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (last_resp) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  assign beat_vld  = (nxt_state == RESP) && is_read && (nxt_cnt >= CNT_W'(FIRST_BEAT));
  assign beat_last = (nxt_state == RESP) && (nxt_cnt == CNT_W'(RESP_LATENCY - 1));
  assign line_base = word_idx & ~IDX_W'(BURST_WORDS - 1);
  assign rd_idx    = line_base + IDX_W'(nxt_cnt - CNT_W'(FIRST_BEAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_read    <= 1'b0;
      word_idx   <= '0;
      wdata_q    <= '0;
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
      mem_rlast  <= 1'b0;
      mem_wack   <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      mem_rvalid <= beat_vld;
      mem_rlast  <= beat_vld && beat_last;
      mem_wack   <= beat_last && !is_read;
      mem_rdata  <= beat_vld ? mem[rd_idx] : '0;
      if (accept) begin
        is_read  <= mem_read_en;
        word_idx <= mem_addr[IDX_W+1:2];
        wdata_q  <= mem_wdata;
      end
    end
  end

  // Array is never reset; a write aborted by reset never reaches last_resp.
  always_ff @(posedge clk) begin
    if (last_resp && !is_read) begin
      mem[word_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus random line reads and
// word writes compared against a word-array model of the memory.
module tb_data_memory_responder;

  localparam int MEM_WORDS = 4096;
  localparam int REQ       = 5;
  localparam int RSP       = 5;
  localparam int BW        = 4;
  localparam int OCC       = REQ + RSP;
  localparam logic [15:0] EXP_VLD  = 16'(((1 << BW) - 1) << (OCC - BW + 1));
  localparam logic [15:0] EXP_LAST = 16'(1 << OCC);

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid, mem_rlast, mem_wack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  data_memory_responder #(
    .MEM_WORDS(MEM_WORDS), .REQ_LATENCY(REQ), .RESP_LATENCY(RSP), .BURST_WORDS(BW)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_rlast(mem_rlast), .mem_wack(mem_wack)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [int];
  int          ready_low;
  int          junk;
  logic [15:0] vld_mask, last_mask, wack_mask;
  logic [31:0] beats [$];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] exp_beat(input logic [31:0] a, input int k);
    int base;
    base = widx(a) - (widx(a) % BW);
    return ref_mem.exists(base + k) ? ref_mem[base + k] : 32'h0;
  endfunction

  // Issues one request at the current negedge and records the next OCC+1 cycles.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int busy_cyc);
    ready_low = 0; junk = 0;
    vld_mask = '0; last_mask = '0; wack_mask = '0;
    beats.delete();
    mem_read_en = r; mem_write_en = w; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    for (int c = 1; c <= OCC + 1; c++) begin
      @(negedge clk);
      if (!mem_ready) ready_low++;
      if (mem_rvalid) begin
        vld_mask[c] = 1'b1;
        beats.push_back(mem_rdata);
      end else if (mem_rdata != 32'h0) begin
        junk++;
      end
      if (mem_rlast) last_mask[c] = 1'b1;
      if (mem_wack)  wack_mask[c] = 1'b1;
      mem_read_en  = (c == busy_cyc);
      mem_write_en = 1'b0;
      if (c == busy_cyc) mem_addr = a ^ 32'h0000_0100;
    end
    if (w && !r) ref_mem[widx(a)] = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", mem_ready); end
    n_cmp++;
    if ({mem_rvalid, mem_rlast, mem_wack} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b want 000", {mem_rvalid, mem_rlast, mem_wack});
    end
    n_cmp++;
    if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preload;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      d = (i >= 16) ? (32'hA000_0000 + 32'(i - 16)) : $urandom;
      run_txn(1'b0, 1'b1, 32'(i * 4), d, 0);
      n_cmp++;
      if (wack_mask !== EXP_LAST || vld_mask !== 16'h0 || ready_low != OCC) begin
        n_err++;
        $display("FAIL preload_w%0d wack %h vld %h busy %0d want %h 0 %0d",
                 i, wack_mask, vld_mask, ready_low, EXP_LAST, OCC);
      end
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 1'b1, 32'h80 + 32'(i * 4), 32'hB000_0000 + 32'(i), 0);
      run_txn(1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'hC000_0000 + 32'(i), 0);
    end
  endtask

  task automatic test_line_read;
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 0);
    n_cmp++;
    if (ready_low != OCC) begin n_err++; $display("FAIL read_busy got %0d want %0d", ready_low, OCC); end
    n_cmp++;
    if (vld_mask !== EXP_VLD) begin n_err++; $display("FAIL read_rvalid_cycles got %h want %h", vld_mask, EXP_VLD); end
    n_cmp++;
    if (last_mask !== EXP_LAST) begin n_err++; $display("FAIL read_rlast got %h want %h", last_mask, EXP_LAST); end
    n_cmp++;
    if (wack_mask !== 16'h0 || junk != 0) begin
      n_err++; $display("FAIL read_quiet wack %h junk %0d want 0 0", wack_mask, junk);
    end
    n_cmp++;
    if (beats.size() != BW) begin
      n_err++; $display("FAIL read_beats got %0d want %0d", beats.size(), BW);
    end
    for (int k = 0; k < beats.size(); k++) begin
      n_cmp++;
      if (beats[k] !== 32'hA000_0000 + 32'(k)) begin
        n_err++; $display("FAIL read_beat%0d got %h want %h", k, beats[k], 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_write_then_read;
    run_txn(1'b0, 1'b1, 32'h48, 32'hCAFE_F00D, 0);
    n_cmp++;
    if (wack_mask !== EXP_LAST || vld_mask !== 16'h0) begin
      n_err++; $display("FAIL write_wack got %h vld %h want %h 0", wack_mask, vld_mask, EXP_LAST);
    end
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 0);
    n_cmp++;
    if (beats.size() != BW || beats[2] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL raw_beat2 got %h (n=%0d) want cafef00d", beats[2], beats.size());
    end
  endtask

  task automatic test_read_wins;
    run_txn(1'b1, 1'b1, 32'h80, 32'h1234_5678, 0);
    n_cmp++;
    if (wack_mask !== 16'h0 || vld_mask !== EXP_VLD) begin
      n_err++; $display("FAIL both_en wack %h vld %h want 0 %h", wack_mask, vld_mask, EXP_VLD);
    end
    run_txn(1'b1, 1'b0, 32'h80, 32'h0, 0);
    n_cmp++;
    if (beats.size() != BW || beats[0] !== 32'hB000_0000) begin
      n_err++; $display("FAIL both_en_mem got %h want b0000000", beats[0]);
    end
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 3);
    n_cmp++;
    if (vld_mask !== EXP_VLD || ready_low != OCC) begin
      n_err++; $display("FAIL busy_ignored vld %h busy %0d want %h %0d", vld_mask, ready_low, EXP_VLD, OCC);
    end
    run_txn(1'b1, 1'b0, 32'h08, 32'h0, 0);
    n_cmp++;
    if (vld_mask !== EXP_VLD || ready_low != OCC || beats[1] !== exp_beat(32'h08, 1)) begin
      n_err++; $display("FAIL back_to_back vld %h busy %0d beat1 %h want %h %0d %h",
                        vld_mask, ready_low, beats[1], EXP_VLD, OCC, exp_beat(32'h08, 1));
    end
    ready_low = 0; junk = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!mem_ready || mem_rvalid || mem_wack) junk++;
    end
    n_cmp++;
    if (junk != 0) begin n_err++; $display("FAIL idle_quiet got %0d busy cycles want 0", junk); end
  endtask

  task automatic test_reset_mid_write;
    mem_read_en = 1'b0; mem_write_en = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mem_write_en = 1'b0;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_ready, mem_rvalid, mem_rlast, mem_wack} !== 4'b1000 || mem_rdata !== 32'h0) begin
      n_err++; $display("FAIL abort_outputs got %b %h want 1000 0",
                        {mem_ready, mem_rvalid, mem_rlast, mem_wack}, mem_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    junk = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!mem_ready || mem_wack) junk++;
    end
    n_cmp++;
    if (junk != 0) begin n_err++; $display("FAIL abort_idle got %0d bad cycles want 0", junk); end
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 0);
    n_cmp++;
    if (beats.size() != BW || beats[0] !== 32'hC000_0000) begin
      n_err++; $display("FAIL abort_no_write got %h want c0000000", beats[0]);
    end
  endtask

  task automatic test_wrap;
    run_txn(1'b0, 1'b1, 32'h4000, 32'h5A5A_0001, 0);
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, 0);
    n_cmp++;
    if (beats.size() != BW || beats[0] !== 32'h5A5A_0001) begin
      n_err++; $display("FAIL wrap_word0 got %h want 5a5a0001", beats[0]);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      d  = $urandom;
      run_txn(op != 1, op != 0, a, d, 0);
      n_cmp++;
      if (ready_low != OCC || junk != 0) begin
        n_err++; $display("FAIL rnd%0d_busy got %0d junk %0d want %0d 0", i, ready_low, junk, OCC);
      end
      if (op == 1) begin
        n_cmp++;
        if (wack_mask !== EXP_LAST || vld_mask !== 16'h0) begin
          n_err++; $display("FAIL rnd%0d_write wack %h vld %h want %h 0", i, wack_mask, vld_mask, EXP_LAST);
        end
      end else begin
        n_cmp++;
        if (wack_mask !== 16'h0 || vld_mask !== EXP_VLD || last_mask !== EXP_LAST || beats.size() != BW) begin
          n_err++; $display("FAIL rnd%0d_read wack %h vld %h last %h n %0d", i, wack_mask, vld_mask, last_mask, beats.size());
        end
        for (int k = 0; k < beats.size(); k++) begin
          n_cmp++;
          if (beats[k] !== exp_beat(a, k)) begin
            n_err++; $display("FAIL rnd%0d_beat%0d addr %h got %h want %h", i, k, a, beats[k], exp_beat(a, k));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_preload;
    test_line_read;
    test_write_then_read;
    test_read_wins;
    test_back_to_back;
    test_reset_mid_write;
    test_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
